// File: rtl/stopwatch_lap_if.sv
// Control and display bundle between the stopwatch core and its user.
// The user side drives the one-cycle control pulses and reads BCD digits
// plus status flags. The core side does the reverse.
interface stopwatch_lap_if;
    logic       start_resume;
    logic       stop;
    logic       clear;
    logic       lap;
    logic [3:0] min1;
    logic [3:0] min0;
    logic [3:0] sec1;
    logic [3:0] sec0;
    logic [3:0] milSec0;
    logic       running;
    logic       lap_hold;
    logic       overflow;

    modport master (
        output start_resume, stop, clear, lap,
        input  min1, min0, sec1, sec0, milSec0, running, lap_hold, overflow
    );

    modport slave (
        input  start_resume, stop, clear, lap,
        output min1, min0, sec1, sec0, milSec0, running, lap_hold, overflow
    );
endinterface

// File: rtl/stopwatch_lap.sv
// Single-clock BCD stopwatch with a tenths-of-a-second prescaler, a
// start/run/pause state machine, a lap (split) freeze and a choice of wrap
// or saturate behaviour at the maximum count. Every digit advances on the
// one system clock through a tick enable, so no derived clocks exist.
module stopwatch_lap #(
    parameter int unsigned TICK_DIV     = 5000000,
    parameter int unsigned MIN_TENS_MOD = 6,
    parameter int unsigned SATURATE     = 0
) (
    input  logic           clk,
    input  logic           reset,
    stopwatch_lap_if.slave bus
);

    // A single-cycle period still needs a one-bit prescaler to keep widths legal
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0] MIN1_MAX = 4'(MIN_TENS_MOD - 1);
    localparam bit SAT = (SATURATE != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_n;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_n;
    logic          running_q;
    logic          overflow_q;
    logic          lap_hold_q;

    logic [3:0] min1_q, min0_q, sec1_q, sec0_q, milsec0_q;
    logic [3:0] min1_n, min0_n, sec1_n, sec0_n, milsec0_n;
    logic [3:0] lap_min1, lap_min0, lap_sec1, lap_sec0, lap_milsec0;

    logic tick;
    logic at_max;

    // The prescaler only advances in RUN when no stop is pending, so a stop
    // that coincides with the terminal count suppresses the tick entirely
    assign tick = (state_q == RUN) && !bus.stop && (presc_q == PRESC_LAST);

    assign at_max = (min1_q == MIN1_MAX) && (min0_q == 4'd9) &&
                    (sec1_q == 4'd5) && (sec0_q == 4'd9) &&
                    (milsec0_q == 4'd9);

    // Next prescaler value: count in RUN, hold everywhere else
    always_comb begin
        presc_n = presc_q;
        if ((state_q == RUN) && !bus.stop) begin
            if (presc_q == PRESC_LAST) begin
                presc_n = '0;
            end else begin
                presc_n = presc_q + PW'(1);
            end
        end
    end

    // Next digit values: ripple the carry through the BCD chain in one step;
    // the wrap at the maximum falls out naturally, saturation holds instead
    always_comb begin
        min1_n    = min1_q;
        min0_n    = min0_q;
        sec1_n    = sec1_q;
        sec0_n    = sec0_q;
        milsec0_n = milsec0_q;
        if (tick && !(SAT && at_max)) begin
            if (milsec0_q == 4'd9) begin
                milsec0_n = 4'd0;
                if (sec0_q == 4'd9) begin
                    sec0_n = 4'd0;
                    if (sec1_q == 4'd5) begin
                        sec1_n = 4'd0;
                        if (min0_q == 4'd9) begin
                            min0_n = 4'd0;
                            if (min1_q == MIN1_MAX) begin
                                min1_n = 4'd0;
                            end else begin
                                min1_n = min1_q + 4'd1;
                            end
                        end else begin
                            min0_n = min0_q + 4'd1;
                        end
                    end else begin
                        sec1_n = sec1_q + 4'd1;
                    end
                end else begin
                    sec0_n = sec0_q + 4'd1;
                end
            end else begin
                milsec0_n = milsec0_q + 4'd1;
            end
        end
    end

    // Next state: clear beats stop beats start_resume; a saturated overflow
    // parks the watch in PAUSE until clear or reset
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start_resume && !bus.stop) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_n = PAUSE;
                end else if (SAT && tick && at_max) begin
                    state_n = PAUSE;
                end
            end
            PAUSE: begin
                if (bus.start_resume && !bus.stop && !(SAT && overflow_q)) begin
                    state_n = RUN;
                end
            end
            default: state_n = IDLE;
        endcase
        if (bus.clear) begin
            state_n = IDLE;
        end
    end

    // State, prescaler, live digits and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
            min1_q     <= 4'd0;
            min0_q     <= 4'd0;
            sec1_q     <= 4'd0;
            sec0_q     <= 4'd0;
            milsec0_q  <= 4'd0;
        end else if (bus.clear) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
            min1_q     <= 4'd0;
            min0_q     <= 4'd0;
            sec1_q     <= 4'd0;
            sec0_q     <= 4'd0;
            milsec0_q  <= 4'd0;
        end else begin
            state_q    <= state_n;
            presc_q    <= presc_n;
            running_q  <= (state_n == RUN);
            if (tick && at_max) begin
                overflow_q <= 1'b1;
            end
            min1_q    <= min1_n;
            min0_q    <= min0_n;
            sec1_q    <= sec1_n;
            sec0_q    <= sec0_n;
            milsec0_q <= milsec0_n;
        end
    end

    // Lap freeze: capture the pre-tick live digits in RUN, release on any
    // later lap pulse regardless of state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_hold_q  <= 1'b0;
            lap_min1    <= 4'd0;
            lap_min0    <= 4'd0;
            lap_sec1    <= 4'd0;
            lap_sec0    <= 4'd0;
            lap_milsec0 <= 4'd0;
        end else if (bus.clear) begin
            lap_hold_q  <= 1'b0;
            lap_min1    <= 4'd0;
            lap_min0    <= 4'd0;
            lap_sec1    <= 4'd0;
            lap_sec0    <= 4'd0;
            lap_milsec0 <= 4'd0;
        end else if (bus.lap) begin
            if (lap_hold_q) begin
                lap_hold_q <= 1'b0;
            end else if (state_q == RUN) begin
                lap_hold_q  <= 1'b1;
                lap_min1    <= min1_q;
                lap_min0    <= min0_q;
                lap_sec1    <= sec1_q;
                lap_sec0    <= sec0_q;
                lap_milsec0 <= milsec0_q;
            end
        end
    end

    // Display mux driven purely from registers
    assign bus.min1     = lap_hold_q ? lap_min1    : min1_q;
    assign bus.min0     = lap_hold_q ? lap_min0    : min0_q;
    assign bus.sec1     = lap_hold_q ? lap_sec1    : sec1_q;
    assign bus.sec0     = lap_hold_q ? lap_sec0    : sec0_q;
    assign bus.milSec0  = lap_hold_q ? lap_milsec0 : milsec0_q;
    assign bus.running  = running_q;
    assign bus.lap_hold = lap_hold_q;
    assign bus.overflow = overflow_q;

endmodule
